memory_stage: RTL

- Pipeline MEM stage, directly downstream of the execute stage and its EM register.
- Consumes RegWriteM, ResultSrcM, MemWriteM, ALUoutM, funct3M, RdM, Rd2M and inc_PCM.
- Drives a data-memory port with a req/ready handshake, aligns stores and sign/zero-extends loads, and raises StallMem while memory is busy.
- Contains the MW pipeline register that feeds writeback.

---
 rtl/memory_stage_pkg.sv | 40 ++++
 rtl/memory_stage_if.sv | 21 ++
 rtl/memory_stage_align.sv | 64 ++++++
 rtl/memory_stage.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: result-source and funct3
// encodings, the access FSM states and access-size decoding.
package mem_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } acc_size_t;

    // Unknown funct3 codes fall back to a full-word access for both directions.
    function automatic acc_size_t size_of(input logic [2:0] funct3, input logic is_store);
        acc_size_t size;
        size = SZ_W;
        if (is_store) begin
            if (funct3 == F3_B)      size = SZ_B;
            else if (funct3 == F3_H) size = SZ_H;
        end else begin
            if (funct3 == F3_B || funct3 == F3_BU)      size = SZ_B;
            else if (funct3 == F3_H || funct3 == F3_HU) size = SZ_H;
        end
        return size;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory port of the MEM stage: a single req/ready handshake carrying
// word address, byte enables and lane-aligned write data.
interface memory_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/memory_stage_align.sv
// Purely combinational lane logic: store byte enables / replicated write data,
// load byte/half selection with sign or zero extension, and misalignment.
module load_store_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data,
    output logic        o_misalign
);

    acc_size_t   w_acc_size;
    acc_size_t   w_ld_size;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        w_acc_size  = size_of(i_funct3, i_is_store);
        w_ld_size   = size_of(i_funct3, 1'b0);
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        o_misalign  = 1'b0;
        o_load_data = i_rdata;

        case (w_acc_size)
            SZ_B: begin
                if (i_is_store) begin
                    o_be    = 4'b0001 << i_offset;
                    o_wdata = {4{i_store_data[7:0]}};
                end
            end
            SZ_H: begin
                o_misalign = i_offset[0];
                if (i_is_store) begin
                    o_be    = i_offset[1] ? 4'b1100 : 4'b0011;
                    o_wdata = {2{i_store_data[15:0]}};
                end
            end
            default: o_misalign = |i_offset;
        endcase

        case (i_offset)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

        // funct3[2] marks the unsigned load variants.
        case (w_ld_size)
            SZ_B:    o_load_data = i_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    o_load_data = i_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: drives the data-memory handshake, stalls the front of the
// pipe while memory is busy, aborts on timeout and holds the MW register.
module memory_stage
    import mem_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  MemWriteM,
    input  logic [31:0]           ALUoutM,
    input  logic [2:0]            funct3M,
    input  logic [4:0]            RdM,
    input  logic [31:0]           Rd2M,
    input  logic [31:0]           inc_PCM,
    memory_stage_if.master        mem_bus,
    output logic                  StallMem,
    output logic                  Misalign,
    output logic                  BusErr,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [31:0]           ALUoutW,
    output logic [31:0]           ReadDataW,
    output logic [4:0]            RdW,
    output logic [31:0]           inc_PCW
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    mem_state_t  r_state;
    mem_state_t  w_state_next;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_cnt_inc;
    logic        w_mem_acc;
    logic        w_misalign_raw;
    logic        w_misalign;
    logic        w_access;
    logic        w_req;
    logic        w_stall;
    logic        w_abort;
    logic [31:0] w_load_data;

    logic        r_regwrite;
    logic [1:0]  r_result_src;
    logic [31:0] r_aluout;
    logic [31:0] r_read_data;
    logic [4:0]  r_rd;
    logic [31:0] r_inc_pc;
    logic        r_misalign;
    logic        r_bus_err;

    load_store_align u_align (
        .i_offset     (ALUoutM[1:0]),
        .i_funct3     (funct3M),
        .i_is_store   (MemWriteM),
        .i_store_data (Rd2M),
        .i_rdata      (mem_bus.mem_rdata),
        .o_be         (mem_bus.mem_be),
        .o_wdata      (mem_bus.mem_wdata),
        .o_load_data  (w_load_data),
        .o_misalign   (w_misalign_raw)
    );

    assign w_mem_acc  = MemWriteM | (ResultSrcM == RES_MEM);
    assign w_misalign = w_mem_acc & w_misalign_raw;
    assign w_access   = w_mem_acc & ~w_misalign_raw;
    assign w_cnt_inc  = r_wait_cnt + 8'd1;

    always_comb begin
        w_state_next = r_state;
        w_req        = 1'b0;
        w_stall      = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_req = 1'b1;
                    if (!mem_bus.mem_ready) begin
                        w_stall      = 1'b1;
                        w_state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                // A ready arriving on the timeout cycle still completes normally.
                if (mem_bus.mem_ready) begin
                    w_req        = 1'b1;
                    w_state_next = IDLE;
                end else if (w_cnt_inc == WAIT_LIMIT) begin
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_req   = 1'b1;
                    w_stall = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Reset overrides the request and stall combinationally, not just at the next edge.
    assign mem_bus.mem_req  = w_req & rst_n;
    assign mem_bus.mem_we   = w_req & rst_n & MemWriteM;
    assign mem_bus.mem_addr = {ALUoutM[31:2], 2'b00};
    assign StallMem         = w_stall & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wait_cnt <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            r_state    <= w_state_next;
            r_wait_cnt <= (r_state == IDLE) ? 8'd0 : w_cnt_inc;
        end
    end

    // MW register: a stall inserts a bubble; abort and misalign suppress the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwrite   <= 1'b0;
            r_result_src <= 2'b00;
            r_aluout     <= 32'd0;
            r_read_data  <= 32'd0;
            r_rd         <= 5'd0;
            r_inc_pc     <= 32'd0;
            r_misalign   <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_regwrite   <= RegWriteM & ~w_stall & ~w_abort & ~w_misalign;
            r_result_src <= ResultSrcM;
            r_aluout     <= ALUoutM;
            r_read_data  <= w_load_data;
            r_rd         <= RdM;
            r_inc_pc     <= inc_PCM;
            r_misalign   <= w_misalign;
            r_bus_err    <= w_abort;
        end
    end

    assign RegWriteW  = r_regwrite;
    assign ResultSrcW = r_result_src;
    assign ALUoutW    = r_aluout;
    assign ReadDataW  = r_read_data;
    assign RdW        = r_rd;
    assign inc_PCW    = r_inc_pc;
    assign Misalign   = r_misalign;
    assign BusErr     = r_bus_err;

endmodule
